// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM slew controller: register map offsets,
// field positions, channel register layout and scheduler state encoding.
package pwm_pkg;

   localparam int unsigned ADDR_W      = 12;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned FIELD_W     = 8;

   localparam int unsigned CH_REG_BASE = 0;
   localparam int unsigned TGT_LSB     = 0;
   localparam int unsigned STEP_LSB    = 8;
   localparam int unsigned EN_BIT      = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } fsm_state_e;

   // Channel register word as seen on the dmem bus
   typedef struct packed {
      logic [14:0]        rsvd;
      logic               en;
      logic [FIELD_W-1:0] step;
      logic [FIELD_W-1:0] target;
   } ch_reg_t;

   // Prescaler reload register sits directly after the channel block
   function automatic int unsigned presc_off(input int unsigned num_ch);
      return num_ch;
   endfunction

endpackage

// File: rtl/pwm_slew_controller_if.sv
// dmem-side register bus of the slew controller: write strobe, word address,
// write data and registered read data.
interface pwm_slew_controller_if;

   logic                        wEn;
   logic [pwm_pkg::ADDR_W-1:0]  addr;
   logic [pwm_pkg::DATA_W-1:0]  dataIn;
   logic [pwm_pkg::DATA_W-1:0]  dataOut;

   modport master (output wEn, output addr, output dataIn, input dataOut);
   modport slave  (input wEn, input addr, input dataIn, output dataOut);

endinterface

// File: rtl/pwm_prescaler.sv
// Update-tick prescaler: counts 0..reload, ticks for one cycle at reload and
// wraps; a reload write restarts the count.
module pwm_prescaler #(
   parameter int unsigned PRESC_W     = 16,
   parameter int unsigned PRESC_RESET = 9999
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               wr_i,
   input  logic [PRESC_W-1:0] wdata_i,
   output logic [PRESC_W-1:0] reload_o,
   output logic               tick_c_o
);

   logic [PRESC_W-1:0] count_q, count_d;
   logic [PRESC_W-1:0] reload_q, reload_d;

   assign tick_c_o = (count_q == reload_q);
   assign reload_o = reload_q;

   always_comb begin
      reload_d = reload_q;
      count_d  = count_q + PRESC_W'(1);
      if (tick_c_o) begin
         count_d = '0;
      end
      if (wr_i) begin
         reload_d = wdata_i;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q  <= '0;
         reload_q <= PRESC_W'(PRESC_RESET);
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
      end
   end

endmodule

// File: rtl/pwm_slew_controller.sv
// Memory-mapped PWM duty sequencer: per-channel target/step/enable registers,
// a prescaled tick and a round-robin scheduler that slews each duty to target.
module pwm_slew_controller
   import pwm_pkg::*;
#(
   parameter int unsigned       NUM_CH      = 4,
   parameter int unsigned       DUTY_W      = 8,
   parameter int unsigned       PRESC_W     = 16,
   parameter int unsigned       PRESC_RESET = 9999,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'hFF0
) (
   input  logic                     clock,
   input  logic                     CPU_RESETN,
   pwm_slew_controller_if.slave     bus,
   output logic [NUM_CH*DUTY_W-1:0] duty,
   output logic [NUM_CH-1:0]        busy,
   output logic [NUM_CH-1:0]        done
);

   localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned PRESC_OFF = presc_off(NUM_CH);

   logic [ADDR_W-1:0]  off_c;
   ch_reg_t            wr_c;
   ch_reg_t            rd_c;
   logic [NUM_CH-1:0]  ch_wr_c;
   logic               presc_wr_c;
   logic               tick_c;
   logic [PRESC_W-1:0] reload_c;
   logic [DATA_W-1:0]  rdata_c;
   logic [DATA_W-1:0]  rdata_q;
   logic               unused_rsvd_c;

   logic [DUTY_W-1:0]  tgt_q  [NUM_CH];
   logic [DUTY_W-1:0]  tgt_d  [NUM_CH];
   logic [DUTY_W-1:0]  step_q [NUM_CH];
   logic [DUTY_W-1:0]  step_d [NUM_CH];
   logic [DUTY_W-1:0]  cur_q  [NUM_CH];
   logic [DUTY_W-1:0]  cur_d  [NUM_CH];
   logic [NUM_CH-1:0]  en_q, en_d;
   logic [NUM_CH-1:0]  done_q, done_d;

   fsm_state_e         state_q;
   logic [CH_W-1:0]    ch_q;
   logic               pending_q;

   // One saturating step toward target; DUTY_W+1 bits expose overflow/underflow
   function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] cur,
                                              input logic [DUTY_W-1:0] tgt,
                                              input logic [DUTY_W-1:0] step);
      logic [DUTY_W:0] sum;
      logic [DUTY_W:0] dif;
      sum = {1'b0, cur} + {1'b0, step};
      dif = {1'b0, cur} - {1'b0, step};
      if (step == '0) begin
         slew = tgt;
      end else if (cur < tgt) begin
         slew = (sum > {1'b0, tgt}) ? tgt : sum[DUTY_W-1:0];
      end else if (cur > tgt) begin
         slew = (dif[DUTY_W] || (dif[DUTY_W-1:0] < tgt)) ? tgt : dif[DUTY_W-1:0];
      end else begin
         slew = cur;
      end
   endfunction

   assign off_c         = bus.addr - BASE_ADDR;
   assign wr_c          = ch_reg_t'(bus.dataIn);
   assign presc_wr_c    = bus.wEn && (off_c == ADDR_W'(PRESC_OFF));
   assign unused_rsvd_c = ^wr_c.rsvd;

   always_comb begin
      ch_wr_c = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         ch_wr_c[n] = bus.wEn && (off_c == ADDR_W'(CH_REG_BASE + n));
      end
   end

   pwm_prescaler #(
      .PRESC_W     (PRESC_W),
      .PRESC_RESET (PRESC_RESET)
   ) u_prescaler (
      .clk_i    (clock),
      .rst_ni   (CPU_RESETN),
      .wr_i     (presc_wr_c),
      .wdata_i  (bus.dataIn[PRESC_W-1:0]),
      .reload_o (reload_c),
      .tick_c_o (tick_c)
   );

   // Register writes take priority over a same-cycle scheduled update
   always_comb begin
      tgt_d  = tgt_q;
      step_d = step_q;
      cur_d  = cur_q;
      en_d   = en_q;
      done_d = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (ch_wr_c[n]) begin
            tgt_d[n]  = DUTY_W'(wr_c.target);
            step_d[n] = DUTY_W'(wr_c.step);
            en_d[n]   = wr_c.en;
            if (!wr_c.en) begin
               cur_d[n] = '0;
            end
         end else if ((state_q == SWEEP) && (ch_q == CH_W'(n)) && en_q[n]) begin
            cur_d[n]  = slew(cur_q[n], tgt_q[n], step_q[n]);
            done_d[n] = (cur_q[n] != tgt_q[n]) && (cur_d[n] == tgt_q[n]);
         end
      end
   end

   always_comb begin
      rdata_c = '0;
      rd_c    = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (off_c == ADDR_W'(CH_REG_BASE + n)) begin
            rd_c.en     = en_q[n];
            rd_c.step   = FIELD_W'(step_q[n]);
            rd_c.target = FIELD_W'(tgt_q[n]);
            rdata_c     = DATA_W'(rd_c);
         end
      end
      if (off_c == ADDR_W'(PRESC_OFF)) begin
         rdata_c = DATA_W'(reload_c);
      end
   end

   always_ff @(posedge clock or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         for (int n = 0; n < NUM_CH; n++) begin
            tgt_q[n]  <= '0;
            step_q[n] <= '0;
            cur_q[n]  <= '0;
         end
         en_q    <= '0;
         done_q  <= '0;
         rdata_q <= '0;
      end else begin
         tgt_q   <= tgt_d;
         step_q  <= step_d;
         cur_q   <= cur_d;
         en_q    <= en_d;
         done_q  <= done_d;
         rdata_q <= rdata_c;
      end
   end

   // Scheduler: one channel per cycle; a tick during a sweep is held one deep
   always_ff @(posedge clock or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         pending_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (tick_c || pending_q) begin
                  state_q   <= SWEEP;
                  ch_q      <= '0;
                  pending_q <= 1'b0;
               end
            end
            SWEEP: begin
               if (tick_c) begin
                  pending_q <= 1'b1;
               end
               if (ch_q == CH_W'(NUM_CH - 1)) begin
                  state_q <= IDLE;
               end else begin
                  ch_q <= ch_q + CH_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      duty = '0;
      busy = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         duty[n*DUTY_W +: DUTY_W] = en_q[n] ? cur_q[n] : '0;
         busy[n]                  = en_q[n] && (cur_q[n] != tgt_q[n]);
      end
   end

   assign done        = done_q;
   assign bus.dataOut = rdata_q;

endmodule

// File: tb/tb_pwm_slew_controller.sv
// Directed bench for pwm_slew_controller with a queued expected-value scoreboard.
module tb_pwm_slew_controller;

   localparam logic [11:0] BASE = 12'hFF0;

   logic        clock = 1'b0;
   logic        CPU_RESETN = 1'b0;
   logic [31:0] duty;
   logic [3:0]  busy;
   logic [3:0]  done;

   pwm_slew_controller_if bus ();

   pwm_slew_controller #(
      .NUM_CH      (4),
      .DUTY_W      (8),
      .PRESC_W     (16),
      .PRESC_RESET (9999),
      .BASE_ADDR   (12'hFF0)
   ) dut (
      .clock      (clock),
      .CPU_RESETN (CPU_RESETN),
      .bus        (bus.slave),
      .duty       (duty),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   int done0_cnt = 0;
   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) if (done[0]) done0_cnt <= done0_cnt + 1;

   logic [31:0] exp_q[$];
   int n_assert = 0;
   int n_fail   = 0;

   task automatic push(input logic [31:0] e);
      exp_q.push_back(e);
   endtask

   task automatic compare(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_assert++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
         return;
      end
      e = exp_q.pop_front();
      assert (obs === e) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      bus.wEn    = 1'b1;
      bus.addr   = a;
      bus.dataIn = d;
      @(negedge clock);
      bus.wEn    = 1'b0;
      bus.dataIn = '0;
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] e);
      push(e);
      bus.addr = a;
      @(negedge clock);
      compare(tag, bus.dataOut);
   endtask

   // Poll each falling edge until a channel's duty leaves prev (bounded)
   task automatic wait_duty(input int ch, input string tag, input logic [7:0] prev,
                            output logic [7:0] v);
      bit got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (duty[ch*8 +: 8] !== prev) begin
            got = 1'b1;
            break;
         end
         @(negedge clock);
      end
      v = duty[ch*8 +: 8];
      n_assert++;
      assert (got) else begin
         n_fail++;
         $error("FAIL %s: timeout, duty still %0h", tag, v);
      end
   endtask

   function automatic logic [31:0] chw(input logic en, input logic [7:0] step,
                                       input logic [7:0] tgt);
      return {15'b0, en, step, tgt};
   endfunction

   initial begin
      logic [7:0] ramp [4];
      logic [7:0] prev;
      logic [7:0] v;
      logic [7:0] c;
      int         t;
      int         cnt0;
      int         r;

      ramp = '{8'd10, 8'd20, 8'd30, 8'd35};
      bus.wEn    = 1'b0;
      bus.addr   = '0;
      bus.dataIn = '0;
      CPU_RESETN = 1'b0;
      repeat (3) @(negedge clock);
      CPU_RESETN = 1'b1;

      push(32'd0); compare("rst_duty", duty);
      push(32'd0); compare("rst_busy", 32'(busy));
      push(32'd0); compare("rst_done", 32'(done));
      push(32'd0); compare("rst_dout", bus.dataOut);
      rd("presc_rst", BASE + 12'd4, 32'd9999);

      // Ramp ch0 to 35 in steps of 10 with a tick every 4 cycles
      wr(BASE + 12'd4, 32'd3);
      wr(BASE, chw(1'b1, 8'd10, 8'd35));
      push(32'd1); compare("ch0_busy_start", 32'(busy[0]));
      cnt0 = done0_cnt;
      prev = 8'd0;
      t    = 0;
      for (int i = 0; i < 4; i++) begin
         push(32'(ramp[i]));
         wait_duty(0, "ch0_wait", prev, v);
         compare("ch0_duty", 32'(v));
         push(32'(ramp[i] == 8'd35)); compare("ch0_done", 32'(done[0]));
         push(32'(ramp[i] != 8'd35)); compare("ch0_busy", 32'(busy[0]));
         if (i > 0) begin
            push(32'd5); compare("ch0_period", 32'(cyc - t));
         end
         t    = cyc;
         prev = v;
      end
      repeat (20) @(negedge clock);
      push(32'(cnt0 + 1)); compare("ch0_done_cnt", 32'(done0_cnt));
      push(32'd35);        compare("ch0_hold", 32'(duty[7:0]));
      rd("ch0_reg", BASE, 32'h0001_0A23);

      // ch1: downward saturation and step==0 jump
      wr(BASE + 12'd1, chw(1'b1, 8'd0, 8'd200));
      push(32'd200); wait_duty(1, "ch1_wait", 8'd0, v);   compare("ch1_to200", 32'(v));
      wr(BASE + 12'd1, chw(1'b1, 8'd100, 8'd5));
      push(32'd100); wait_duty(1, "ch1_wait", 8'd200, v); compare("ch1_down", 32'(v));
      push(32'd5);   wait_duty(1, "ch1_wait", 8'd100, v); compare("ch1_sat", 32'(v));
      wr(BASE + 12'd1, chw(1'b1, 8'd0, 8'd77));
      push(32'd77);  wait_duty(1, "ch1_wait", 8'd5, v);   compare("ch1_step0", 32'(v));
      rd("ch1_reg", BASE + 12'd1, 32'h0001_004D);

      wr(BASE + 12'd5, 32'hFFFF_FFFF);
      rd("unmapped", BASE + 12'd5, 32'd0);
      rd("presc_rd", BASE + 12'd4, 32'd3);

      // Reload 0: back-to-back sweeps, one update per channel every 5 cycles
      wr(BASE + 12'd4, 32'd0);
      wr(BASE + 12'd3, chw(1'b1, 8'd1, 8'd200));
      wr(BASE + 12'd2, chw(1'b1, 8'd1, 8'd100));
      push(32'd1); wait_duty(3, "ch3_wait", 8'd0, v); compare("ch3_first", 32'(v));
      push(32'd2); wait_duty(3, "ch3_wait", 8'd1, v); compare("ch3_second", 32'(v));
      t = cyc;
      for (int k = 0; k < 4; k++) begin
         prev = v;
         push(32'(prev) + 32'd1);
         wait_duty(3, "ch3_wait", prev, v);
         compare("ch3_step", 32'(v));
         push(32'd5); compare("ch3_period", 32'(cyc - t));
         t = cyc;
      end

      // ch2 is updated three cycles after a ch3 change becomes visible
      repeat (3) @(negedge clock);
      c = duty[23:16];
      wr(BASE + 12'd2, chw(1'b1, 8'd1, 8'd50));
      push(32'(c)); compare("ch2_collide_hold", 32'(duty[23:16]));
      push(32'(c) + 32'd1); wait_duty(2, "ch2_wait", c, v); compare("ch2_after", 32'(v));
      rd("ch2_reg", BASE + 12'd2, chw(1'b1, 8'd1, 8'd50));

      wr(BASE + 12'd2, chw(1'b0, 8'd1, 8'd50));
      push(32'd0); compare("ch2_disabled", 32'(duty[23:16]));
      rd("ch2_reg_dis", BASE + 12'd2, 32'h0000_0132);
      wr(BASE + 12'd2, chw(1'b1, 8'd1, 8'd50));
      push(32'd1); wait_duty(2, "ch2_wait", 8'd0, v); compare("ch2_reenable", 32'(v));

      // Asynchronous reset between edges while sweeping
      #2;
      CPU_RESETN = 1'b0;
      #1;
      push(32'd0); compare("amid_duty", duty);
      push(32'd0); compare("amid_busy", 32'(busy));
      push(32'd0); compare("amid_done", 32'(done));
      push(32'd0); compare("amid_dout", bus.dataOut);
      @(negedge clock);
      @(negedge clock);
      CPU_RESETN = 1'b1;
      r = cyc;
      rd("presc_after_rst", BASE + 12'd4, 32'd9999);
      rd("ch3_after_rst", BASE + 12'd3, 32'd0);
      wr(BASE, chw(1'b1, 8'd5, 8'd50));
      while (cyc < r + 10000) @(negedge clock);
      push(32'd0); compare("no_early_tick", 32'(duty[7:0]));
      @(negedge clock);
      push(32'd5); compare("first_tick", 32'(duty[7:0]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
